fft_bin_streamer: RTL and testbench

//  Output-side companion to top_fft_cordic: the reader for the FFT's parallel result array.

---
 rtl/fft_bin_streamer_if.sv | 21 ++
 rtl/fft_bin_streamer.sv | 143 ++++++++++++++
 tb/tb_fft_bin_streamer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bin_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bin_streamer_if
// Purpose  : Valid/ready bin-beat bus carrying one complex FFT bin per beat.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_bin_streamer_if #(
  parameter int POINT_FFT_POW2 = 4,
  parameter int FRAC_BITS      = 15
);
  logic                      valid;
  logic                      ready;
  logic signed [FRAC_BITS:0] re;
  logic signed [FRAC_BITS:0] im;
  logic [POINT_FFT_POW2-1:0] bin;
  logic                      last;

  modport master (output valid, re, im, bin, last, input ready);
  modport slave  (input valid, re, im, bin, last, output ready);
endinterface
`default_nettype wire

// File: rtl/fft_bin_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fft_bin_streamer
// Purpose  : Snapshots the FFT result array a fixed latency after start and
//            streams it one bin per valid/ready beat, optionally de-bit-reversed.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bin_streamer #(
  parameter int POINT_FFT_POW2 = 4,
  parameter int POINT_FFT      = 16,
  parameter int FRAC_BITS      = 15,
  parameter int LATENCY        = 48,
  parameter bit BIT_REVERSE    = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   fft_start_i,
  input  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] fft_data_i,
  fft_bin_streamer_if.master                     m,
  output logic                                   busy_o,
  output logic                                   overrun_o
);

  localparam int                        c_cnt_w    = $clog2(LATENCY + 1);
  localparam logic [c_cnt_w-1:0]        c_lat_last = c_cnt_w'(LATENCY - 1);
  localparam logic [c_cnt_w-1:0]        c_cnt_one  = c_cnt_w'(1);
  localparam logic [POINT_FFT_POW2-1:0] c_idx_last = {POINT_FFT_POW2{1'b1}};
  localparam logic [POINT_FFT_POW2-1:0] c_idx_one  = POINT_FFT_POW2'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [c_cnt_w-1:0]                    r_cnt;
  logic [POINT_FFT_POW2-1:0]             r_idx;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] r_frame;
  logic                                  r_overrun;

  logic                      w_handshake;
  logic                      w_final;
  logic                      w_cnt_clr;
  logic                      w_capture;
  logic                      w_advance;
  logic                      w_overrun_nxt;
  logic [POINT_FFT_POW2-1:0] w_sel;

  assign w_handshake = (r_state == S_STREAM) && m.ready;
  assign w_final     = w_handshake && (r_idx == c_idx_last);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_capture     = 1'b0;
    w_advance     = 1'b0;
    w_overrun_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fft_start_i) begin
          w_state_nxt = S_WAIT;
          w_cnt_clr   = 1'b1;
        end
      end
      S_WAIT: begin
        w_overrun_nxt = fft_start_i;
        if (r_cnt == c_lat_last) begin
          w_state_nxt = S_STREAM;
          w_capture   = 1'b1;
        end
      end
      S_STREAM: begin
        // A start landing on the final handshake chains the next frame instead of overrunning.
        w_overrun_nxt = fft_start_i && !w_final;
        if (w_handshake) begin
          w_advance = 1'b1;
          if (w_final) begin
            if (fft_start_i) begin
              w_state_nxt = S_WAIT;
              w_cnt_clr   = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun_nxt;
      if (w_cnt_clr)              r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + c_cnt_one;
      if (w_capture) begin
        r_frame <= fft_data_i;
        r_idx   <= '0;
      end else if (w_advance) begin
        r_idx <= w_final ? '0 : r_idx + c_idx_one;
      end
    end
  end

  generate
    if (BIT_REVERSE) begin : g_bitrev
      for (genvar b = 0; b < POINT_FFT_POW2; b++) begin : g_bit
        assign w_sel[b] = r_idx[POINT_FFT_POW2-1-b];
      end
    end else begin : g_natural
      assign w_sel = r_idx;
    end
  endgenerate

  assign m.valid  = (r_state == S_STREAM);
  assign m.bin    = r_idx;
  assign m.last   = m.valid && (r_idx == c_idx_last);
  assign busy_o   = (r_state != S_IDLE);
  assign overrun_o = r_overrun;

  always_comb begin
    m.re = '0;
    m.im = '0;
    if (r_state == S_STREAM) begin
      m.re = r_frame[w_sel][0];
      m.im = r_frame[w_sel][1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bin_streamer
// Purpose  : Directed + randomized check of natural- and bit-reversed streamers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bin_streamer;
  localparam int POW2 = 4;
  localparam int NPT  = 16;
  localparam int FB   = 15;
  localparam int LAT  = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic [NPT-1:0][1:0][FB:0] fft_data;
  logic [FB:0] d_re [NPT];
  logic [FB:0] d_im [NPT];
  logic [FB:0] s_re [NPT];
  logic [FB:0] s_im [NPT];
  logic busy0, busy1, ovr0, ovr1;
  int checks = 0;
  int errors = 0;
  int ncyc;

  always #5 clk = ~clk;

  always_comb begin
    for (int n = 0; n < NPT; n++) begin
      fft_data[n][0] = d_re[n];
      fft_data[n][1] = d_im[n];
    end
  end

  fft_bin_streamer_if #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB)) if0 ();
  fft_bin_streamer_if #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB)) if1 ();
  assign if0.ready = ready;
  assign if1.ready = ready;

  fft_bin_streamer #(.POINT_FFT_POW2(POW2), .POINT_FFT(NPT), .FRAC_BITS(FB),
                     .LATENCY(LAT), .BIT_REVERSE(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .fft_start_i(start), .fft_data_i(fft_data),
    .m(if0), .busy_o(busy0), .overrun_o(ovr0));

  fft_bin_streamer #(.POINT_FFT_POW2(POW2), .POINT_FFT(NPT), .FRAC_BITS(FB),
                     .LATENCY(LAT), .BIT_REVERSE(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .fft_start_i(start), .fft_data_i(fft_data),
    .m(if1), .busy_o(busy1), .overrun_o(ovr1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < POW2; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int n = 0; n < NPT; n++) begin
      d_re[n] = 16'(n * 256);
      d_im[n] = 16'(-n);
    end
  endtask

  task automatic set_random();
    for (int n = 0; n < NPT; n++) begin
      d_re[n] = 16'($urandom);
      d_im[n] = 16'($urandom);
    end
  endtask

  // Called just after the start edge; expects valid exactly LAT edges later.
  task automatic wait_capture();
    for (int k = 1; k <= LAT; k++) begin
      if (k == LAT) begin
        for (int n = 0; n < NPT; n++) begin
          s_re[n] = d_re[n];
          s_im[n] = d_im[n];
        end
      end
      tick();
      check("wait_busy", {30'b0, busy0, busy1}, 32'h3);
      check("wait_valid", {30'b0, if0.valid, if1.valid}, (k == LAT) ? 32'h3 : 32'h0);
      check("wait_overrun", {30'b0, ovr0, ovr1}, 32'h0);
    end
    set_random();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {30'b0, busy0, busy1}, 32'h3);
    wait_capture();
  endtask

  task automatic stream(input int rmode, input int ovr_beat, input bit b2b,
                        input int rst_after, input bit pat, output int cycles);
    int hs = 0;
    int cyc = 0;
    bit exp_ovr = 1'b0;
    bit fired = 1'b0;
    bit aborted = 1'b0;
    while (hs < NPT && !aborted) begin
      if (cyc >= 300) begin
        check("stream_timeout", 32'(hs), 32'(NPT));
        aborted = 1'b1;
      end else begin
        case (rmode)
          0:       ready = 1'b1;
          1:       ready = (cyc % 2 == 0);
          default: ready = 1'($urandom % 2);
        endcase
        start = 1'b0;
        if (b2b && hs == NPT - 1) begin
          ready = 1'b1;
          start = 1'b1;
        end
        if (ovr_beat == hs && !fired) begin
          start = 1'b1;
          fired = 1'b1;
        end
        check("valid", {30'b0, if0.valid, if1.valid}, 32'h3);
        check("bin0", 32'(if0.bin), 32'(hs));
        check("bin1", 32'(if1.bin), 32'(hs));
        check("last", {30'b0, if0.last, if1.last}, (hs == NPT - 1) ? 32'h3 : 32'h0);
        check("re0", {16'b0, if0.re}, {16'b0, s_re[hs]});
        check("im0", {16'b0, if0.im}, {16'b0, s_im[hs]});
        check("re1", {16'b0, if1.re}, {16'b0, s_re[rev(hs)]});
        check("im1", {16'b0, if1.im}, {16'b0, s_im[rev(hs)]});
        check("overrun", {30'b0, ovr0, ovr1}, exp_ovr ? 32'h3 : 32'h0);
        if (pat && hs == 1)  check("br_k1",  {16'b0, if1.re}, 32'd2048);
        if (pat && hs == 3)  check("br_k3",  {16'b0, if1.re}, 32'd3072);
        if (pat && hs == 15) check("br_k15", {16'b0, if1.re}, 32'd3840);
        exp_ovr = start && !(ready && hs == NPT - 1);
        tick();
        cyc++;
        start = 1'b0;
        if (ready) hs++;
        if (rst_after >= 0 && hs == rst_after + 1) begin
          rst_n = 1'b0;
          tick();
          check("rst_valid", {30'b0, if0.valid, if1.valid}, 32'h0);
          check("rst_busy", {30'b0, busy0, busy1}, 32'h0);
          rst_n = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    if (!aborted) begin
      check("end_overrun", {30'b0, ovr0, ovr1}, exp_ovr ? 32'h3 : 32'h0);
      check("end_valid", {30'b0, if0.valid, if1.valid}, 32'h0);
      check("end_busy", {30'b0, busy0, busy1}, b2b ? 32'h3 : 32'h0);
    end
    ready = 1'b0;
    cycles = cyc;
  endtask

  initial begin
    set_pattern();
    // Reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_valid", {30'b0, if0.valid, if1.valid}, 32'h0);
      check("rst_busy", {30'b0, busy0, busy1}, 32'h0);
      check("rst_overrun", {30'b0, ovr0, ovr1}, 32'h0);
      check("rst_last", {30'b0, if0.last, if1.last}, 32'h0);
      check("rst_bin", {24'b0, if0.bin, if1.bin}, 32'h0);
      check("rst_data", {if0.re, if1.im}, 32'h0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", {30'b0, busy0, busy1}, 32'h0);

    // Pattern frame, ready always high
    set_pattern();
    do_start();
    stream(0, -1, 1'b0, -1, 1'b1, ncyc);
    check("frame_cycles_full", 32'(ncyc), 32'd16);

    // Backpressure: ready toggles 1,0,1,0...
    set_pattern();
    do_start();
    stream(1, -1, 1'b0, -1, 1'b1, ncyc);
    check("frame_cycles_toggle", 32'(ncyc), 32'd31);

    // Mid-stream overrun at beat 4, then back-to-back start on the final beat
    set_pattern();
    do_start();
    stream(0, 4, 1'b1, -1, 1'b1, ncyc);
    wait_capture();
    stream(0, -1, 1'b0, -1, 1'b0, ncyc);

    // Reset after beat 5, then a full frame from k=0
    set_pattern();
    do_start();
    stream(0, -1, 1'b0, 5, 1'b1, ncyc);
    tick();
    check("post_rst_idle", {30'b0, busy0, busy1}, 32'h0);
    set_pattern();
    do_start();
    stream(0, -1, 1'b0, -1, 1'b1, ncyc);

    // Randomized frames with random backpressure and random stray starts
    for (int f = 0; f < 4; f++) begin
      set_random();
      do_start();
      stream(2, int'($urandom_range(0, NPT - 2)), 1'b0, -1, 1'b0, ncyc);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
